uart_byte_tx: RTL and testbench

//   Serial transmitter downstream of the title-screen drawer: consumes the byte stream it

---
 rtl/pong_uart_pkg.sv | 21 ++
 rtl/uart_bit_timer.sv | 27 ++
 rtl/uart_byte_tx.sv | 129 ++++++++++++
 tb/tb_uart_byte_tx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pong_uart_pkg.sv
// rtl/pong_uart_pkg.sv - shared UART transmitter states, line constants and parity helper
package pong_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE,
    GUARD
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   DATA_BITS       = 8;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period counter; bit_tick marks the last cycle of each serial bit
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);

  localparam int               WIDTH = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(CLKS_PER_BIT - 1);

  logic [WIDTH-1:0] count;

  // clear takes priority so every state change starts a fresh, full bit period
  always_ff @(posedge clock) begin
    if (reset || clear || bit_tick) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

  assign bit_tick = (count == LAST);

endmodule

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - UART byte transmitter (8N1, LSB first) with post-byte guard window.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int GUARD_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       done,
  output logic       tx,
  output logic       busy
);

  import pong_uart_pkg::*;

  localparam int                GUARD_W    = $clog2(GUARD_CYCLES);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);
  localparam int                IDX_W      = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DATA_BITS - 1);

  tx_state_t              state;
  tx_state_t              state_next;
  logic [DATA_BITS-1:0]   shift;
  logic [IDX_W-1:0]       bit_idx;
  logic [GUARD_W-1:0]     guard_cnt;
  logic                   bit_tick;
  logic                   timer_clear;
  logic                   accept;

  assign accept      = (state == IDLE) && din_valid;
  assign timer_clear = (state_next != state);
  assign busy        = (state != IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .bit_tick(bit_tick)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_bit;

  always_ff @(posedge clock) begin
    if (reset) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= even_parity(din);
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tx         = UART_IDLE_LEVEL;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (din_valid) state_next = START;
      end
      START: begin
        tx = 1'b0;
        if (bit_tick) state_next = DATA;
      end
      DATA: begin
        tx = shift[0];
        if (bit_tick && (bit_idx == IDX_LAST)) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx = parity_bit;
        if (bit_tick) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = GUARD;
      end
      GUARD: begin
        // drawer's dataout is stale for a few cycles after done; din_valid ignored here
        if (guard_cnt == GUARD_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shift   <= '0;
      bit_idx <= '0;
    end else if (accept) begin
      shift   <= din;
      bit_idx <= '0;
    end else if ((state == DATA) && bit_tick) begin
      shift <= shift >> 1;
      if (bit_idx != IDX_LAST) bit_idx <= bit_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || (state != GUARD)) begin
      guard_cnt <= '0;
    end else begin
      guard_cnt <= guard_cnt + GUARD_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb/tb_uart_byte_tx.sv - directed bench for uart_byte_tx including a title-drawer byte stream model
module tb_uart_byte_tx;

  localparam int CPB          = 4;
  localparam int GUARD        = 8;
  localparam int DRAWER_WORDS = 256;
  localparam int NB           = 2 * DRAWER_WORDS;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR   = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       done;
  logic       tx;
  logic       busy;

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [15:0] rom [0:4095];
  logic [7:0] rx_q [$];
  int         rx_errs = 0;
  bit         mon_en  = 1'b0;

  always #5 clock = ~clock;

  uart_byte_tx #(
    .CLKS_PER_BIT(CPB),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .din      (din),
    .din_valid(din_valid),
    .done     (done),
    .tx       (tx),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic exp_tx(input logic [7:0] b, input int c);
    int p;
    p = (c - 1) / CPB;
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    if (PAR && (p == 9)) return ^b;
    return 1'b1;
  endfunction

  function automatic logic [7:0] rom_byte(input int i);
    logic [15:0] w;
    w = rom[i / 2];
    return (i % 2 != 0) ? w[15:8] : w[7:0];
  endfunction

  task automatic send(input logic [7:0] b);
    din       = b;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  // entered at cycle 1 after acceptance; leaves at the first IDLE cycle after GUARD
  task automatic frame_check(input logic [7:0] b, input bit poke);
    for (int c = 1; c <= NBITS * CPB; c++) begin
      check($sformatf("tx_%02h_c%0d", b, c), tx, exp_tx(b, c));
      check("done_in_frame", done, 1'b0);
      check("busy_in_frame", busy, 1'b1);
      step();
    end
    check("done_pulse", done, 1'b1);
    check("tx_at_done", tx, 1'b1);
    for (int g = 1; g <= GUARD; g++) begin
      if (poke) din_valid = (g < GUARD);
      step();
      check("busy_guard", busy, 1'b1);
      check("done_guard", done, 1'b0);
      check("tx_guard", tx, 1'b1);
    end
    step();
    check("busy_idle", busy, 1'b0);
    check("done_idle", done, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    forever begin
      @(posedge clock);
      #2;
      if (mon_en && (tx == 1'b0)) begin
        repeat (2) @(posedge clock);
        #2;
        if (tx !== 1'b0) rx_errs++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clock);
          #2;
          b[i] = tx;
        end
        if (PAR) begin
          repeat (CPB) @(posedge clock);
          #2;
          if (tx !== ^b) rx_errs++;
        end
        repeat (CPB) @(posedge clock);
        #2;
        if (tx !== 1'b1) rx_errs++;
        rx_q.push_back(b);
      end
    end
  end

  initial begin
    bit seen_done;
    bit line_moved;
    int t;

    reset     = 1'b1;
    din       = 8'h00;
    din_valid = 1'b0;
    repeat (3) step();
    check("reset_tx", tx, 1'b1);
    check("reset_done", done, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset = 1'b0;
    step();
    check("idle_tx", tx, 1'b1);

    send(8'hA5);
    frame_check(8'hA5, 1'b0);

    // din_valid held high; din changes while frame 1 is in flight
    din       = 8'h3C;
    din_valid = 1'b1;
    step();
    din = 8'h01;
    frame_check(8'h3C, 1'b0);
    step();
    din_valid = 1'b0;
    frame_check(8'h01, 1'b0);

    // reset during DATA bit 3 (cycles 17..20 of the frame)
    send(8'h96);
    repeat (17) step();
    check("busy_before_abort", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    seen_done  = 1'b0;
    line_moved = 1'b0;
    repeat (60) begin
      step();
      if (done) seen_done = 1'b1;
      if (tx !== 1'b1 || busy !== 1'b0) line_moved = 1'b1;
    end
    check("no_done_after_abort", seen_done, 1'b0);
    check("idle_after_abort", line_moved, 1'b0);
    send(8'h5A);
    frame_check(8'h5A, 1'b0);

    // din_valid only inside GUARD must not start a frame
    send(8'hC3);
    frame_check(8'hC3, 1'b1);
    line_moved = 1'b0;
    repeat (20) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0) line_moved = 1'b1;
    end
    check("guard_valid_ignored", line_moved, 1'b0);

    send(8'h07);
    frame_check(8'h07, 1'b0);
    send(8'h03);
    frame_check(8'h03, 1'b0);

    // title-drawer model: sticky sendready, dataout updated a few cycles after done
    for (int a = 0; a < 4096; a++) rom[a] = 16'(a * 40503 + 12345);
    mon_en    = 1'b1;
    din       = rom_byte(0);
    din_valid = 1'b1;
    for (int i = 0; i < NB; i++) begin
      t = 0;
      while (done !== 1'b1 && t < 400) begin
        step();
        t++;
      end
      check($sformatf("drawer_wait_%0d", i), 32'(t < 400), 32'd1);
      if (t >= 400) break;
      if (i == NB - 1) begin
        din_valid = 1'b0;
      end else begin
        din = ~din;
        repeat (4) step();
        din = rom_byte(i + 1);
      end
    end
    repeat (60) step();
    mon_en = 1'b0;
    check("rx_count", rx_q.size(), NB);
    check("rx_framing", rx_errs, 0);
    for (int i = 0; i < rx_q.size() && i < NB; i++) begin
      check($sformatf("rx_byte_%0d", i), rx_q[i], rom_byte(i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
